// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared constants and types for the digit glyph reader
package glyph_pkg;

    localparam int         GLYPH_WORDS = 1024;
    localparam int         ADDR_W      = 10;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sel;
        logic       last;
    } pix_entry_t;

    // Travels alongside an outstanding ROM read until its data returns.
    typedef struct packed {
        logic vld;
        logic sel;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/glyph_pix_fifo.sv
// rtl/glyph_pix_fifo.sv - first-word-fall-through pixel buffer
module glyph_pix_fifo
    import glyph_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  pix_entry_t             i_wdata,
    input  logic                   i_pop,
    output pix_entry_t             o_rdata,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    pix_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && (r_count != (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/digit_glyph_reader.sv
// rtl/digit_glyph_reader.sv - reads two digit glyphs from the ROM bank and streams their bytes
module digit_glyph_reader
    import glyph_pkg::*;
#(
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        digit_a,
    input  logic [3:0]        digit_b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ena_a,
    output logic              ena_b,
    output logic [3:0]        result_1,
    output logic [3:0]        result_2,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        r_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sel,
    output logic              pix_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_dig_a;
    logic [3:0]        r_dig_b;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic [CW-1:0]     r_outst;
    rd_tag_t           r_dl [ROM_LAT];

    logic              w_digits_ok;
    logic              w_start_ok;
    logic              w_last_word;
    logic              w_credit;
    logic              w_issue;
    logic              w_capture;
    logic              w_pop;
    logic              w_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [CW:0]       w_inflight;
    pix_entry_t        w_push_entry;
    pix_entry_t        w_head;

    assign w_digits_ok = (digit_a <= DIGIT_MAX) && (digit_b <= DIGIT_MAX);
    assign w_start_ok  = start && w_digits_ok;
    assign w_last_word = (r_count == ADDR_W'(GLYPH_WORDS - 1));

    // Reads already issued but not yet captured must still fit in the FIFO.
    assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_outst};
    assign w_credit   = (w_inflight < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next = RD_A;
                end
            end
            RD_A: begin
                w_issue = w_credit;
                if (w_issue && w_last_word) begin
                    w_next = RD_B;
                end
            end
            RD_B: begin
                w_issue = w_credit;
                if (w_issue && w_last_word) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_outst == '0) && w_empty) begin
                    w_next = FIN;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig_a <= '0;
            r_dig_b <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_outst <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                r_dl[i] <= '0;
            end
        end else begin
            r_err <= (r_state == IDLE) && start && !w_digits_ok;
            if ((r_state == IDLE) && w_start_ok) begin
                r_dig_a <= digit_a;
                r_dig_b <= digit_b;
                r_count <= '0;
                r_addr  <= '0;
            end else if (w_issue) begin
                r_addr  <= r_count;
                r_count <= w_last_word ? '0 : r_count + 1'b1;
            end
            case ({w_issue, w_capture})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
            r_dl[0] <= {w_issue, (r_state == RD_B), w_last_word};
            for (int i = 1; i < ROM_LAT; i++) begin
                r_dl[i] <= r_dl[i-1];
            end
        end
    end

    assign w_capture    = r_dl[ROM_LAT-1].vld;
    assign w_push_entry = {r_data, r_dl[ROM_LAT-1].sel, r_dl[ROM_LAT-1].last};

    glyph_pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign ena_a    = w_issue && (r_state == RD_A);
    assign ena_b    = w_issue && (r_state == RD_B);
    assign address  = w_issue ? r_count : r_addr;
    assign result_1 = r_dig_a;
    assign result_2 = r_dig_b;
    assign busy     = (r_state == RD_A) || (r_state == RD_B) || (r_state == DRAIN);
    assign done     = (r_state == FIN);
    assign err      = r_err;

    // Head fields are masked so an empty buffer presents all zeros.
    assign pix_valid = !w_empty;
    assign w_pop     = pix_valid && pix_ready;
    assign pix_data  = w_empty ? 8'h00 : w_head.data;
    assign pix_sel   = w_empty ? 1'b0 : w_head.sel;
    assign pix_last  = w_empty ? 1'b0 : w_head.last;

endmodule
